// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM encoding and nibble-to-ASCII helper
package uart_pkg;

  localparam logic [7:0] CHR_0  = 8'h30;
  localparam logic [7:0] CHR_X  = 8'h78;
  localparam logic [7:0] CHR_A  = 8'h41;
  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t S_IDLE      = 2'd0;
  localparam fsm_state_t S_START     = 2'd1;
  localparam fsm_state_t S_WAIT_ACK  = 2'd2;
  localparam fsm_state_t S_WAIT_DONE = 2'd3;

  // Uppercase hex digit for one nibble
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return CHR_0 + {4'd0, n};
    else           return CHR_A + {4'd0, n - 4'd10};
  endfunction

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - synchronous word FIFO with registered full flag
module word_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q;
  logic             do_push, do_pop;

  // A push while full is refused even if a pop happens in the same cycle
  assign do_push = push && !full_q;
  assign do_pop  = pop && (count_q != '0);

  // Next occupancy from accepted push/pop
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
    else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
  end

  // Pointers, occupancy and the registered full flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_CNT);
    end
  end

  // Storage array; contents are don't-care while empty so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/uart_hex_printer.sv
// rtl/uart_hex_printer.sv - prints buffered 32-bit words as ASCII hex lines over a byte UART
module uart_hex_printer
  import uart_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int PREFIX_EN   = 1,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        full,
  output logic        idle,
  output logic [7:0]  drop_cnt,
  output logic        ack_err,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         PRE       = (PREFIX_EN != 0) ? 2 : 0;
  localparam int         NCHAR     = PRE + 10;
  localparam logic [3:0] LAST_IDX  = 4'(NCHAR - 1);
  localparam int         TW        = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);

  fsm_state_t  state_q, state_d;
  logic [31:0] shadow_q, shadow_d;
  logic [3:0]  idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]  drop_q;
  logic        ack_err_q, ack_err_d;
  logic        tx_start_q;
  logic [7:0]  tx_data_q, tx_data_d;

  logic        fifo_pop;
  logic [31:0] fifo_dout;
  logic [AW:0] fifo_count;
  logic        fifo_full, fifo_empty;

  word_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Character at position idx of the printed line: optional "0x", 8 digits MSB-first, CR LF
  function automatic logic [7:0] char_at(input logic [31:0] word, input logic [3:0] idx);
    logic [3:0]  k;
    logic [31:0] sh;
    k  = idx - 4'(PRE);
    sh = word >> {3'd7 - k[2:0], 2'b00};
    if (PRE != 0 && idx == 4'd0)      return CHR_0;
    else if (PRE != 0 && idx == 4'd1) return CHR_X;
    else if (k < 4'd8)                return nibble_to_ascii(sh[3:0]);
    else if (k == 4'd8)               return CHR_CR;
    else                              return CHR_LF;
  endfunction

  // Sequencer: tx_data is loaded on entry to START so it is already valid with the start pulse
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    ack_err_d = ack_err_q;
    tx_data_d = tx_data_q;
    fifo_pop  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shadow_d  = fifo_dout;
          idx_d     = 4'd0;
          tx_data_d = char_at(fifo_dout, 4'd0);
          state_d   = S_START;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
          if (tmo_d == TMO_LIMIT) begin
            ack_err_d = 1'b1;
            state_d   = S_START;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            idx_d     = idx_q + 4'd1;
            tx_data_d = char_at(shadow_q, idx_d);
            state_d   = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath registers and the saturating drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      drop_q     <= '0;
      ack_err_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      ack_err_q  <= ack_err_d;
      tx_start_q <= (state_d == S_START);
      tx_data_q  <= tx_data_d;
      if (wr_en && fifo_full && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  assign full     = fifo_full;
  assign idle     = (state_q == S_IDLE) && (fifo_count == '0);
  assign drop_cnt = drop_q;
  assign ack_err  = ack_err_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule
